// File: rtl/tpu_tile_ctrl_pkg.sv
// Shared constants and FSM encoding for the tiled GEMM controller.
// Holds the default array edge and address width used by the tile controller.
package tpu_tile_ctrl_pkg;

    localparam int DEF_DIM    = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        LOAD    = 3'd2,
        DRAIN   = 3'd3,
        COLLECT = 3'd4,
        NEXT    = 3'd5,
        FIN     = 3'd6
    } state_t;

endpackage

// File: rtl/tpu_tile_ctrl_addr_gen.sv
// tile_addr_gen: buffer address arithmetic for one tile position.
// Pure combinational; products formed at ADDR_W+CNT_W bits, low bits kept.
module tile_addr_gen
    import tpu_tile_ctrl_pkg::*;
#(
    parameter int DIM    = DEF_DIM,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int R_W    = $clog2(DEF_DIM + 1)
) (
    input  logic [CNT_W-1:0]  ti,
    input  logic [CNT_W-1:0]  tj,
    input  logic [CNT_W-1:0]  kk,
    input  logic [CNT_W-1:0]  k,
    input  logic [CNT_W-1:0]  tn,
    input  logic [R_W-1:0]    r,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-1:0] addr_out
);

    localparam int W = ADDR_W + CNT_W;

    // A/B words are k apart per tile; OUT rows are DIM apart per tile
    always_comb begin
        addr_a   = ADDR_W'(W'(ti) * W'(k) + W'(kk));
        addr_b   = ADDR_W'(W'(tj) * W'(k) + W'(kk));
        addr_out = ADDR_W'((W'(ti) * W'(tn) + W'(tj)) * W'(DIM) + W'(r));
    end

endmodule

// File: rtl/tpu_tile_ctrl.sv
// tpu_tile_ctrl: sequences one TPU over the A/B/OUT buffers, tile by tile.
// Optional macro TPU_TILE_CTRL_PERF_EN adds a 32-bit busy-cycle counter.
module tpu_tile_ctrl
    import tpu_tile_ctrl_pkg::*;
#(
    parameter int DIM    = DEF_DIM,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  m,
    input  logic [CNT_W-1:0]  k,
    input  logic [CNT_W-1:0]  n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              wen_a,
    output logic              wen_b,
    output logic [ADDR_W-1:0] addr_out,
    output logic              wen_out,
    output logic              tpu_in_valid,
    output logic              tpu_in_last,
    input  logic              tpu_out_valid,
    input  logic              tpu_done
`ifdef TPU_TILE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int R_W = $clog2(DIM + 1);
    localparam int CW  = 2 * CNT_W + ADDR_W + 1;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  tm_q;
    logic [CNT_W-1:0]  tn_q;
    logic [CNT_W-1:0]  kk;
    logic [CNT_W-1:0]  ti;
    logic [CNT_W-1:0]  tj;
    logic [R_W-1:0]    r;
    logic              done_seen;
    logic              err_q;
    logic              in_valid_q;
    logic              in_last_q;

    logic [CNT_W-1:0]  tm_in;
    logic [CNT_W-1:0]  tn_in;
    logic [CW-1:0]     lim;
    logic              cfg_err;
    logic              load_end;
    logic              last_tile;
    logic              tile_end;
    logic              beat;
    logic [ADDR_W-1:0] a_raw;
    logic [ADDR_W-1:0] b_raw;
    logic [ADDR_W-1:0] o_raw;

    // ceil(x/DIM) written so x+DIM-1 cannot overflow CNT_W
    assign tm_in = m / CNT_W'(DIM) + CNT_W'(m % CNT_W'(DIM) != '0);
    assign tn_in = n / CNT_W'(DIM) + CNT_W'(n % CNT_W'(DIM) != '0);

    // a zero tile count means the matching dimension was zero
    assign lim     = CW'(1) << ADDR_W;
    assign cfg_err = (tm_q == '0) || (tn_q == '0) || (k_q == '0)
                  || (CW'(tm_q) * CW'(k_q) > lim)
                  || (CW'(tn_q) * CW'(k_q) > lim)
                  || (CW'(tm_q) * CW'(tn_q) * CW'(DIM) > lim);

    assign load_end  = (kk == k_q - CNT_W'(1));
    assign last_tile = (ti == tm_q - CNT_W'(1)) && (tj == tn_q - CNT_W'(1));
    assign beat      = (state == COLLECT) && tpu_out_valid && (r < R_W'(DIM));
    assign tile_end  = (r == R_W'(DIM)) && (done_seen || tpu_done);

    tile_addr_gen #(
        .DIM    (DIM),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .R_W    (R_W)
    ) u_addr (
        .ti       (ti),
        .tj       (tj),
        .kk       (kk),
        .k        (k_q),
        .tn       (tn_q),
        .r        (r),
        .addr_a   (a_raw),
        .addr_b   (b_raw),
        .addr_out (o_raw)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CHECK;
            CHECK:   state_nx = cfg_err ? FIN : LOAD;
            LOAD:    if (load_end) state_nx = DRAIN;
            DRAIN:   state_nx = COLLECT;
            COLLECT: if (tile_end) state_nx = NEXT;
            NEXT:    state_nx = last_tile ? FIN : LOAD;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // latched dims, k/tile/row counters and the sticky tpu_done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= '0;
            tm_q      <= '0;
            tn_q      <= '0;
            kk        <= '0;
            ti        <= '0;
            tj        <= '0;
            r         <= '0;
            done_seen <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                k_q  <= k;
                tm_q <= tm_in;
                tn_q <= tn_in;
            end
            if (tpu_done) done_seen <= 1'b1;
            case (state)
                CHECK: begin
                    kk        <= '0;
                    ti        <= '0;
                    tj        <= '0;
                    r         <= '0;
                    done_seen <= 1'b0;
                    err_q     <= cfg_err;
                end
                LOAD: kk <= load_end ? '0 : kk + CNT_W'(1);
                COLLECT: if (beat) r <= r + R_W'(1);
                NEXT: begin
                    r         <= '0;
                    done_seen <= 1'b0;
                    if (tj == tn_q - CNT_W'(1)) begin
                        tj <= '0;
                        ti <= ti + CNT_W'(1);
                    end else begin
                        tj <= tj + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // operands reach the TPU one cycle after their SRAM read address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_last_q  <= 1'b0;
        end else begin
            in_valid_q <= (state == LOAD);
            in_last_q  <= (state == LOAD) && load_end;
        end
    end

    // outputs decoded from state; addresses held at 0 outside their phase
    always_comb begin
        busy         = (state != IDLE);
        done         = (state == FIN);
        err          = (state == FIN) && err_q;
        addr_a       = '0;
        addr_b       = '0;
        if (state == LOAD) begin
            addr_a = a_raw;
            addr_b = b_raw;
        end
        wen_a        = 1'b0;
        wen_b        = 1'b0;
        addr_out     = (state == COLLECT) ? o_raw : '0;
        wen_out      = beat;
        tpu_in_valid = in_valid_q;
        tpu_in_last  = in_last_q;
    end

`ifdef TPU_TILE_CTRL_PERF_EN
    // busy-cycle counter, restarted per accepted job, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        perf_cycles <= '0;
        else if (state == IDLE && start) perf_cycles <= '0;
        else if (busy && ~&perf_cycles) perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule
